// File: rtl/seg7_frame_decoder.sv
// seg7_frame_decoder
//   Recovers a signed 4-bit value from a serialized two-digit, active-low
//   seven-segment frame (sign digit + magnitude digit). The frame is 14 bits,
//   MSB first: a1..g1 (sign) then a0..g0 (magnitude). Frames that do not form
//   a legal signed-digit encoding are reported as errors, and a frame that
//   stalls for TIMEOUT idle cycles is aborted with an error result.
//
// Parameters
//   TIMEOUT  idle cycles tolerated between strobes inside a frame (2..1023)
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   rst      in   synchronous active-high reset
//   sdata    in   serial frame bit, sampled when sstrobe=1
//   sstrobe  in   sdata qualifier, one frame bit per strobed cycle
//   sframe   in   with sstrobe=1, marks the bit as frame bit 1
//   value    out  decoded two's-complement value, held between valid pulses
//   error    out  error status of the last completed or aborted frame
//   valid    out  one-cycle pulse presenting a new value/error
//   busy     out  high while a frame is being shifted in
module seg7_frame_decoder #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdata,
    input  logic       sstrobe,
    input  logic       sframe,
    output logic [3:0] value,
    output logic       error,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [9:0] IDLE_LAST = 10'(TIMEOUT - 1);

    state_t      state_q;
    // Only the first 13 bits are ever stored: the 14th bit is decoded together
    // with them on the capturing edge, so the result is registered on entry to
    // DONE and valid can be high during the DONE cycle itself.
    logic [12:0] shreg_q;
    logic [3:0]  count_q;
    logic [9:0]  idle_q;
    logic [3:0]  value_q;
    logic        error_q;
    logic        valid_q;
    logic        busy_q;

    logic [13:0] frame_d;
    logic [3:0]  mag_n;
    logic        mag_ok;
    logic        sign_blank;
    logic        sign_minus;
    logic [3:0]  value_d;
    logic        error_d;

    assign frame_d = {shreg_q, sdata};

    // Magnitude digit lookup (abcdefg, active-low).
    always_comb begin
        mag_ok = 1'b1;
        mag_n  = 4'd0;
        unique case (frame_d[6:0])
            7'b0000001: mag_n = 4'd0;
            7'b1001111: mag_n = 4'd1;
            7'b0010010: mag_n = 4'd2;
            7'b0000110: mag_n = 4'd3;
            7'b1001100: mag_n = 4'd4;
            7'b0100100: mag_n = 4'd5;
            7'b0100000: mag_n = 4'd6;
            7'b0001111: mag_n = 4'd7;
            7'b0000000: mag_n = 4'd8;
            default:    mag_ok = 1'b0;
        endcase
    end

    assign sign_blank = (frame_d[13:7] == 7'b1111111);
    assign sign_minus = (frame_d[13:7] == 7'b1111110);

    // Blank sign covers 0..7, minus covers -1..-8; everything else is illegal.
    always_comb begin
        value_d = 4'd0;
        error_d = 1'b1;
        if (mag_ok) begin
            if (sign_blank && (mag_n != 4'd8)) begin
                value_d = mag_n;
                error_d = 1'b0;
            end else if (sign_minus && (mag_n != 4'd0)) begin
                value_d = 4'd0 - mag_n;
                error_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
            idle_q  <= '0;
            value_q <= '0;
            error_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (sstrobe && sframe) begin
                        shreg_q <= {12'd0, sdata};
                        count_q <= 4'd1;
                        idle_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    if (sstrobe) begin
                        idle_q <= '0;
                        if (sframe) begin
                            // Restart: the partial frame is dropped silently.
                            shreg_q <= {12'd0, sdata};
                            count_q <= 4'd1;
                        end else if (count_q == 4'd13) begin
                            count_q <= '0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b1;
                            value_q <= value_d;
                            error_q <= error_d;
                            state_q <= DONE;
                        end else begin
                            shreg_q <= frame_d[12:0];
                            count_q <= count_q + 4'd1;
                        end
                    end else if (idle_q == IDLE_LAST) begin
                        // This edge is the TIMEOUT-th idle cycle: abort.
                        idle_q  <= '0;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        value_q <= '0;
                        error_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        idle_q <= idle_q + 10'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign value = value_q;
    assign error = error_q;
    assign valid = valid_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Self-checking bench for seg7_frame_decoder: expected {value,error} results
// are queued as each frame's last bit is driven and compared by a monitor on
// every valid pulse; the scenario tasks add timing and status checks inline.
module tb_seg7_frame_decoder;

    localparam int unsigned TO = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       sdata;
    logic       sstrobe;
    logic       sframe;
    logic [3:0] value;
    logic       error;
    logic       valid;
    logic       busy;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;
    int unsigned pulse_cnt = 0;
    int          cyc       = 0;
    logic [4:0]  exp_q[$];
    int          pulse_cyc[$];

    seg7_frame_decoder #(.TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst    (rst),
        .sdata  (sdata),
        .sstrobe(sstrobe),
        .sframe (sframe),
        .value  (value),
        .error  (error),
        .valid  (valid),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            logic [4:0] e;
            pulse_cnt++;
            pulse_cyc.push_back(cyc);
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard: unexpected valid pulse value=%b error=%b at cycle %0d",
                         value, error, cyc);
            end else begin
                e = exp_q.pop_front();
                if ({value, error} !== e)
                    $display("FAIL scoreboard: value/error got %b/%b expected %b/%b",
                             value, error, e[4:1], e[0]);
                else
                    pass_cnt++;
            end
            total_cnt++;
            if (busy !== 1'b0)
                $display("FAIL busy_at_valid: got %b expected 0", busy);
            else
                pass_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [13:0] encode(input int v);
        int         m;
        logic [6:0] sg;
        logic [6:0] mg;
        sg = (v < 0) ? 7'b1111110 : 7'b1111111;
        m  = (v < 0) ? -v : v;
        case (m)
            0:       mg = 7'b0000001;
            1:       mg = 7'b1001111;
            2:       mg = 7'b0010010;
            3:       mg = 7'b0000110;
            4:       mg = 7'b1001100;
            5:       mg = 7'b0100100;
            6:       mg = 7'b0100000;
            7:       mg = 7'b0001111;
            default: mg = 7'b0000000;
        endcase
        return {sg, mg};
    endfunction

    // Called just after a rising edge; holds the strobe for exactly one cycle.
    task automatic strobe(input logic b, input logic f);
        sdata   = b;
        sstrobe = 1'b1;
        sframe  = f;
        @(posedge clk);
        #1;
        sstrobe = 1'b0;
        sframe  = 1'b0;
        sdata   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends frame bits lo..hi (0 = bit 1); the expectation is queued with bit 14.
    task automatic send_range(input logic [13:0] fr, input int lo, input int hi,
                              input logic [4:0] exp);
        for (int i = lo; i <= hi; i++) begin
            if (i == 13) exp_q.push_back(exp);
            strobe(fr[13-i], (i == 0) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [13:0] fr, input logic [4:0] exp);
        send_range(fr, 0, 13, exp);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        total_cnt++;
        if ({value, error, valid, busy} !== 7'd0)
            $display("FAIL reset_outputs: value=%b error=%b valid=%b busy=%b expected all 0",
                     value, error, valid, busy);
        else
            pass_cnt++;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_basic;
        int p0;
        p0 = pulse_cnt;
        send_frame(14'b11111110000110, {4'b0011, 1'b0});
        total_cnt++;
        if ({valid, busy, value, error} !== {1'b1, 1'b0, 4'b0011, 1'b0})
            $display("FAIL basic_done_cycle: valid=%b busy=%b value=%b error=%b expected 1 0 0011 0",
                     valid, busy, value, error);
        else
            pass_cnt++;
        idle(1);
        total_cnt++;
        if (valid !== 1'b0)
            $display("FAIL basic_valid_width: got valid=%b expected 0", valid);
        else
            pass_cnt++;
        total_cnt++;
        if (pulse_cnt != p0 + 1)
            $display("FAIL basic_pulses: got %0d expected %0d", pulse_cnt - p0, 1);
        else
            pass_cnt++;
        idle(2);
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = pulse_cyc.size();
        send_frame(14'b11111100000000, {4'b1000, 1'b0});
        send_frame(14'b11111101001111, {4'b1111, 1'b0});
        idle(2);
        total_cnt++;
        if (pulse_cyc.size() != n0 + 2)
            $display("FAIL b2b_pulses: got %0d expected 2", pulse_cyc.size() - n0);
        else begin
            pass_cnt++;
            total_cnt++;
            if (pulse_cyc[n0+1] - pulse_cyc[n0] != 14)
                $display("FAIL b2b_spacing: got %0d expected 14", pulse_cyc[n0+1] - pulse_cyc[n0]);
            else
                pass_cnt++;
        end
    endtask

    task automatic test_illegal;
        logic [13:0] frames [4];
        frames[0] = 14'b11111100000001;   // minus zero
        frames[1] = 14'b11111110000000;   // blank eight
        frames[2] = 14'b11101110000001;   // illegal sign digit
        frames[3] = 14'b11111111111111;   // illegal magnitude digit
        for (int i = 0; i < 4; i++) begin
            send_frame(frames[i], {4'b0000, 1'b1});
            idle(1);
        end
        idle(1);
    endtask

    task automatic test_all_values;
        for (int v = -8; v <= 7; v++) begin
            send_frame(encode(v), {4'(v), 1'b0});
            idle(1);
        end
        idle(1);
    endtask

    task automatic test_restart;
        int p0;
        p0 = pulse_cnt;
        send_range(14'b11111110000110, 0, 8, 5'd0);
        send_frame(14'b11111111001111, {4'b0001, 1'b0});
        idle(2);
        total_cnt++;
        if (pulse_cnt != p0 + 1)
            $display("FAIL restart_pulses: got %0d expected 1", pulse_cnt - p0);
        else
            pass_cnt++;
    endtask

    task automatic test_timeout;
        send_range(14'b11111110000110, 0, 4, 5'd0);
        exp_q.push_back({4'b0000, 1'b1});
        idle(TO - 1);
        total_cnt++;
        if ({valid, busy} !== 2'b01)
            $display("FAIL timeout_early: valid=%b busy=%b expected 0 1", valid, busy);
        else
            pass_cnt++;
        idle(1);
        total_cnt++;
        if ({valid, busy, value, error} !== {1'b1, 1'b0, 4'b0000, 1'b1})
            $display("FAIL timeout_abort: valid=%b busy=%b value=%b error=%b expected 1 0 0000 1",
                     valid, busy, value, error);
        else
            pass_cnt++;
        idle(1);
        send_frame(14'b11111110100000, {4'b0110, 1'b0});
        idle(2);
    endtask

    task automatic test_timeout_boundary;
        int p0;
        p0 = pulse_cnt;
        send_range(14'b11111101001100, 0, 4, 5'd0);
        idle(TO - 1);
        send_range(14'b11111101001100, 5, 13, {4'b1100, 1'b0});
        idle(2);
        total_cnt++;
        if (pulse_cnt != p0 + 1)
            $display("FAIL timeout_boundary_pulses: got %0d expected 1", pulse_cnt - p0);
        else
            pass_cnt++;
    endtask

    task automatic test_reset_midframe;
        int p0;
        p0 = pulse_cnt;
        send_range(14'b11111110000110, 0, 9, 5'd0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        total_cnt++;
        if ({value, error, valid, busy} !== 7'd0)
            $display("FAIL midframe_reset_outputs: value=%b error=%b valid=%b busy=%b expected all 0",
                     value, error, valid, busy);
        else
            pass_cnt++;
        idle(TO + 5);
        total_cnt++;
        if (pulse_cnt != p0)
            $display("FAIL midframe_reset_pulses: got %0d expected 0", pulse_cnt - p0);
        else
            pass_cnt++;
        send_frame(14'b11111100100100, {4'b1011, 1'b0});
        idle(2);
        total_cnt++;
        if (pulse_cnt != p0 + 1)
            $display("FAIL after_reset_pulses: got %0d expected 1", pulse_cnt - p0);
        else
            pass_cnt++;
    endtask

    initial begin
        rst     = 1'b1;
        sdata   = 1'b0;
        sstrobe = 1'b0;
        sframe  = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_all_values();
        test_restart();
        test_timeout();
        test_timeout_boundary();
        test_reset_midframe();
        total_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d results outstanding expected 0", exp_q.size());
        else
            pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
